// File: rtl/bin2bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

    localparam int BCD_DIGIT_W = 4;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    // Smallest digit count whose decimal range covers 2^width - 1.
    function automatic int min_digits(input int width);
        longint unsigned maxv;
        longint unsigned p;
        int d;
        maxv = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        p = 1;
        d = 0;
        for (int i = 0; i < 21; i++) begin
            if (p <= maxv) begin
                p = p * 10;
                d = d + 1;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_adj.sv
// Single BCD digit corrector: adds 3 when the digit is 5 or more.
import bin2bcd_pkg::*;

module bcd_digit_adj (
    input  logic [BCD_DIGIT_W-1:0] i_digit,
    output logic [BCD_DIGIT_W-1:0] o_digit
);

    assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter with start/busy/done handshake.
import bin2bcd_pkg::*;

module bin2bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [WIDTH-1:0]              bin,
    output logic                          busy,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int SW = BCD_DIGIT_W * DIGITS;

    if (WIDTH < 1 || DIGITS < min_digits(WIDTH)) begin : g_bad_cfg
        $error("bin2bcd_seq: DIGITS too small for WIDTH, or WIDTH < 1");
    end

    state_t            r_state;
    state_t            w_nxt_state;
    logic [WIDTH-1:0]  r_shift;
    logic [WIDTH-1:0]  w_nxt_shift;
    logic [SW-1:0]     r_scratch;
    logic [SW-1:0]     w_nxt_scratch;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     w_nxt_cnt;
    logic [SW-1:0]     r_bcd;
    logic [SW-1:0]     w_nxt_bcd;
    logic              r_done;
    logic              w_nxt_done;
    logic [SW-1:0]     w_adj;
    logic [SW+WIDTH-1:0] w_cat;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_digit (r_scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .o_digit (w_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // Correct first, then shift the whole {scratch, shift} window by one.
    assign w_cat = {w_adj, r_shift} << 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_bcd     <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_shift   <= w_nxt_shift;
            r_scratch <= w_nxt_scratch;
            r_cnt     <= w_nxt_cnt;
            r_bcd     <= w_nxt_bcd;
            r_done    <= w_nxt_done;
        end
    end

    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_shift   = r_shift;
        w_nxt_scratch = r_scratch;
        w_nxt_cnt     = r_cnt;
        w_nxt_bcd     = r_bcd;
        w_nxt_done    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_nxt_shift   = bin;
                    w_nxt_scratch = '0;
                    w_nxt_cnt     = CW'(WIDTH);
                    w_nxt_state   = SHIFT;
                end
            end
            SHIFT: begin
                w_nxt_scratch = w_cat[SW+WIDTH-1:WIDTH];
                w_nxt_shift   = w_cat[WIDTH-1:0];
                w_nxt_cnt     = r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    w_nxt_bcd   = w_cat[SW+WIDTH-1:WIDTH];
                    w_nxt_done  = 1'b1;
                    w_nxt_state = IDLE;
                end
            end
            default: w_nxt_state = IDLE;
        endcase
    end

    assign busy = (r_state == SHIFT);
    assign done = r_done;
    assign bcd  = r_bcd;

endmodule
